instr_fetch_unit: RTL and testbench

Instruction fetch and PC sequencing unit that produces the instruction stream feeding the opcode decoder (`op`/`func` fields) and consumes the decoder's branch/jump outcome to redirect the PC. It sits between the instruction memory and the decode stage. It issues sequential fetches, buffers returned words in a 2-entry queue with a valid/ready handshake toward decode, and computes branch, `j`/`jal`, and `jr` targets.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC sequencer: sequential fetch, 2-entry decode queue, redirect on branch/jump.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect target raises sticky fetch_err and halts fetch.
module instr_fetch_unit #(
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic [5:0]        id_op,
  output logic [5:0]        id_func,
  input  logic              rd_valid,
  input  logic              rd_br,
  input  logic              rd_zero,
  input  logic [1:0]        rd_jump,
  input  logic [ADDR_W-1:0] rd_pc_plus4,
  input  logic [15:0]       rd_imm,
  input  logic [25:0]       rd_jtarget,
  input  logic [ADDR_W-1:0] rd_jr_addr,
  output logic              fetch_err
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, inflight_addr_q;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_epoch_q, epoch_q;
  logic [31:0]       q0_instr_q, q1_instr_q, q0_instr_d, q1_instr_d;
  logic [ADDR_W-1:0] q0_pc4_q, q1_pc4_q, q0_pc4_d, q1_pc4_d;

  logic              pop, redirect, issue, push, align_fault;
  logic [2:0]        occ;
  logic [1:0]        push_idx;
  logic [ADDR_W-1:0] target_raw, target;

  assign id_valid    = ~rst & (count_q != 2'd0);
  assign id_instr    = rst ? 32'h0 : q0_instr_q;
  assign id_pc_plus4 = rst ? '0 : q0_pc4_q;
  assign id_op       = id_instr[31:26];
  assign id_func     = id_instr[5:0];
  assign imem_addr   = pc_q;
  assign pop         = id_valid & id_ready;

  assign redirect = rd_valid & (state_q != StHalt) &
                    ((rd_jump != 2'b00) | (rd_br & rd_zero));

  // Jump encoding wins over the branch flag, so jal follows the jump path.
  always_comb begin
    target_raw = rd_pc_plus4 + {{14{rd_imm[15]}}, rd_imm, 2'b00};
    case (rd_jump)
      2'b10:   target_raw = rd_jr_addr;
      2'b01:   target_raw = {rd_pc_plus4[31:28], rd_jtarget, 2'b00};
      default: ;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_q;
  assign align_fault = redirect & (target_raw[1:0] != 2'b00);
  assign target      = target_raw;
  assign fetch_err   = ~rst & fetch_err_q;
`else
  assign align_fault = 1'b0;
  assign target      = target_raw & ~32'h3;
  assign fetch_err   = 1'b0;
`endif

  assign occ      = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue    = ~rst & (state_q == StRun) & ~redirect & (occ < 3'd2);
  assign imem_req = issue;
  // A response issued under an older epoch belongs to a flushed path.
  assign push     = inflight_q & (inflight_epoch_q == epoch_q) & ~redirect;
  assign push_idx = count_q - {1'b0, pop};

  always_comb begin
    q0_instr_d = q0_instr_q;
    q1_instr_d = q1_instr_q;
    q0_pc4_d   = q0_pc4_q;
    q1_pc4_d   = q1_pc4_q;
    count_d    = count_q - {1'b0, pop} + {1'b0, push};
    if (pop) begin
      q0_instr_d = q1_instr_q;
      q0_pc4_d   = q1_pc4_q;
    end
    if (push) begin
      if (push_idx == 2'd0) begin
        q0_instr_d = imem_rdata;
        q0_pc4_d   = inflight_addr_q + 32'd4;
      end else begin
        q1_instr_d = imem_rdata;
        q1_pc4_d   = inflight_addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StBoot;
      pc_q             <= RESET_PC;
      count_q          <= 2'd0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_addr_q  <= '0;
      epoch_q          <= 1'b0;
      q0_instr_q       <= 32'h0;
      q1_instr_q       <= 32'h0;
      q0_pc4_q         <= '0;
      q1_pc4_q         <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   if (align_fault) state_q <= StHalt;
        default: state_q <= state_q;
      endcase
      inflight_q       <= issue;
      inflight_epoch_q <= epoch_q;
      inflight_addr_q  <= pc_q;
      q0_instr_q       <= q0_instr_d;
      q1_instr_q       <= q1_instr_d;
      q0_pc4_q         <= q0_pc4_d;
      q1_pc4_q         <= q1_pc4_d;
      if (redirect) begin
        pc_q    <= target;
        count_q <= 2'd0;
        epoch_q <= ~epoch_q;
      end else begin
        count_q <= count_d;
        if (issue) pc_q <= pc_q + 32'd4;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (align_fault) fetch_err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory returns word = address, scoreboard of
// expected fetch addresses consumed as decode accepts instructions.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_op;
  logic [5:0]  id_func;
  logic        rd_valid;
  logic        rd_br;
  logic        rd_zero;
  logic [1:0]  rd_jump;
  logic [31:0] rd_pc_plus4;
  logic [15:0] rd_imm;
  logic [25:0] rd_jtarget;
  logic [31:0] rd_jr_addr;
  logic        fetch_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_op       (id_op),
    .id_func     (id_func),
    .rd_valid    (rd_valid),
    .rd_br       (rd_br),
    .rd_zero     (rd_zero),
    .rd_jump     (rd_jump),
    .rd_pc_plus4 (rd_pc_plus4),
    .rd_imm      (rd_imm),
    .rd_jtarget  (rd_jtarget),
    .rd_jr_addr  (rd_jr_addr),
    .fetch_err   (fetch_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One-cycle-latency memory whose word equals its address.
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

  // Scoreboard: every accepted instruction must be the next expected address.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      check_eq("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        check_eq("sb_instr", id_instr, e);
        check_eq("sb_pc4", id_pc_plus4, e + 32'd4);
        check_eq("sb_op", 32'(id_op), 32'(e[31:26]));
        check_eq("sb_func", 32'(id_func), 32'(e[5:0]));
      end
    end
  end

  task automatic expect_from(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // Drives a one-cycle redirect with decode stalled, then returns at the R+1 drive point.
  task automatic do_redirect(input logic br, input logic zero, input logic [1:0] jump,
                             input logic [31:0] pc4, input logic [15:0] imm,
                             input logic [25:0] jt, input logic [31:0] jr,
                             input logic [31:0] exp_target, input int n);
    @(posedge clk); #1;
    id_ready = 1'b0; rd_valid = 1'b1; rd_br = br; rd_zero = zero; rd_jump = jump;
    rd_pc_plus4 = pc4; rd_imm = imm; rd_jtarget = jt; rd_jr_addr = jr;
    expect_from(exp_target, n);
    @(negedge clk);
    check_eq("redir_noreq", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    rd_valid = 1'b0; rd_br = 1'b0; rd_zero = 1'b0; rd_jump = 2'b00; id_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; rd_valid = 1'b0; rd_br = 1'b0; rd_zero = 1'b0;
    rd_jump = 2'b00; rd_pc_plus4 = 32'h0; rd_imm = 16'h0; rd_jtarget = 26'h0; rd_jr_addr = 32'h0;

    @(posedge clk); @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(id_valid), 32'd0);
    check_eq("rst_instr", id_instr, 32'd0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);

    // Cycle 0 after reset: boot, all outputs still quiet.
    @(posedge clk); #1;
    rst = 1'b0; id_ready = 1'b1;
    expect_from(32'h0, 40);
    @(negedge clk);
    check_eq("boot_req", 32'(imem_req), 32'd0);
    check_eq("boot_valid", 32'(id_valid), 32'd0);
    check_eq("boot_pc4", id_pc_plus4, 32'd0);

    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      check_eq("seq_req", 32'(imem_req), 32'd1);
      check_eq("seq_addr", imem_addr, 32'(4 * (c - 1)));
      check_eq("seq_valid", 32'(id_valid), (c == 3) ? 32'd1 : 32'd0);
    end
    check_eq("first_instr", id_instr, 32'h0);
    check_eq("first_pc4", id_pc_plus4, 32'h4);
    repeat (5) @(posedge clk);

    // Backpressure: queue fills to two entries and fetch stops.
    #1 id_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("bp_req", 32'(imem_req), 32'd0);
    check_eq("bp_valid", 32'(id_valid), 32'd1);
    check_eq("bp_head", id_instr, sb[0]);
    @(posedge clk); #1 id_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Taken beq: 0x20 + (-2 << 2) = 0x18.
    do_redirect(1'b1, 1'b1, 2'b00, 32'h20, 16'hFFFE, 26'h0, 32'h0, 32'h18, 30);
    @(negedge clk);
    check_eq("beq_valid_r1", 32'(id_valid), 32'd0);
    check_eq("beq_req", 32'(imem_req), 32'd1);
    check_eq("beq_addr", imem_addr, 32'h18);
    @(posedge clk); @(negedge clk);
    check_eq("beq_valid_r2", 32'(id_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("beq_valid_r3", 32'(id_valid), 32'd1);
    check_eq("beq_instr", id_instr, 32'h18);
    repeat (6) @(posedge clk);

    // jal with Br=1 and zero=1: jump path must win.
    do_redirect(1'b1, 1'b1, 2'b01, 32'h4000_0010, 16'h0010, 26'h40, 32'h0, 32'h4000_0100, 30);
    @(negedge clk);
    check_eq("jal_req", 32'(imem_req), 32'd1);
    check_eq("jal_addr", imem_addr, 32'h4000_0100);
    repeat (6) @(posedge clk);

    // jr to a misaligned address.
`ifdef FETCH_ALIGN_CHECK_EN
    do_redirect(1'b0, 1'b0, 2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0102, 32'h0, 0);
    @(negedge clk);
    check_eq("jr_err", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("halt_req", 32'(imem_req), 32'd0);
      check_eq("halt_valid", 32'(id_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    check_eq("halt_err", 32'(fetch_err), 32'd1);
`else
    do_redirect(1'b0, 1'b0, 2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0102, 32'h100, 30);
    @(negedge clk);
    check_eq("jr_req", 32'(imem_req), 32'd1);
    check_eq("jr_addr", imem_addr, 32'h100);
    check_eq("jr_err", 32'(fetch_err), 32'd0);
    repeat (6) @(posedge clk);
`endif

    // Reset coincident with a redirect: reset wins.
    @(posedge clk); #1;
    rst = 1'b1; rd_valid = 1'b1; rd_jump = 2'b01; rd_jtarget = 26'h0C0;
    @(posedge clk); #1;
    rst = 1'b0; rd_valid = 1'b0; rd_jump = 2'b00;
    expect_from(32'h0, 30);
    @(negedge clk);
    check_eq("rr_req", 32'(imem_req), 32'd0);
    check_eq("rr_valid", 32'(id_valid), 32'd0);
    check_eq("rr_err", 32'(fetch_err), 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("rr_req1", 32'(imem_req), 32'd1);
    check_eq("rr_addr", imem_addr, 32'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("rr_stream", 32'(id_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
